uart_rx_decoder: RTL
====================

# uart_rx_decoder

Synthesisable 8N1 UART receiver that decodes the serial stream driven by the system's `usb_uart_txd` output, for FPGA self-checking benches and on-board loopback. It synchronises the raw line, detects and validates start bits, samples mid-bit, and checks the stop bit. Received bytes go into a small show-ahead FIFO drained by a valid/ready handshake. It also flags framing errors and overflow.

## Interface

Parameters:
- `BIT_CYCLES`, 868: `sys_clock` cycles per bit (100 MHz / 115200). Minimum 4.
- `FIFO_DEPTH`, 4: byte entries in the output FIFO. Power of two, at least 2.

Ports:
- `sys_clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `uart_rxd`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  8  FIFO head byte; valid only while `rx_valid`=1.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts the head byte when `rx_valid & rx_ready`.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overflow`  out  1  sticky; set when a good byte arrives while the FIFO is full. Cleared only by `reset`.
- `busy`  out  1  FSM is not in IDLE.

## Operation

Synchroniser:
- `uart_rxd` passes through a 2-flop synchroniser whose flops reset to 1. `rxs` is the second flop.
- The FSM and sampling use only `rxs`.

FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. A bit-period counter `ctr` and a bit index `idx` (0..7) support it.
- **IDLE:** if `rxs`=0, go to START and clear `ctr`.
- **START:** when `ctr` = BIT_CYCLES/2 − 1, sample `rxs`.
  - If 1, the start was a glitch: return to IDLE.
  - If 0, go to DATA with `ctr`=0 and `idx`=0.
- **DATA:** when `ctr` = BIT_CYCLES − 1, sample `rxs` into shift-register bit `idx` (LSB first) and clear `ctr`.
  - After `idx`=7 is sampled, go to STOP.
- **STOP:** when `ctr` = BIT_CYCLES − 1, sample `rxs`.
  - If 1, push the byte and go to IDLE.
  - If 0, pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rxs`=1, then go to IDLE. A held-low line or break never produces bytes.

FIFO:
- Show-ahead: `rx_data` is the head entry, driven from storage with no extra register.
- Occupancy counter is clog2(FIFO_DEPTH)+1 bits wide. Read and write pointers wrap modulo FIFO_DEPTH.
- Pop happens on `rx_valid & rx_ready`.
- A push while full, with no pop in the same cycle, drops the new byte and sets `overflow`. The FIFO contents are unchanged.
- A push and a pop in the same cycle while full: both succeed, count is unchanged, `overflow` is not set.
- A push and a pop in the same cycle while empty cannot occur, because `rx_valid`=0.

Reset:
- `reset` is synchronous and may arrive mid-frame or mid-handshake.
- Next cycle: FSM=IDLE, `ctr`=0, `idx`=0, FIFO empty, synchroniser=1.
- Reset values of outputs: `rx_valid`=0, `frame_err`=0, `overflow`=0, `busy`=0, `rx_data`=don't-care.
- The rest of a frame interrupted by reset is ignored. A trailing low segment of that frame may be decoded as a new start and is then rejected or reported by the normal rules.

## Timing

Let cycle T be the first cycle with `rxs`=0 while in IDLE (2 cycles after the `uart_rxd` edge). With H = BIT_CYCLES/2:
- Start sample: cycle T+H.
- Data bit k (k = 0..7): cycle T+H+(k+1)·BIT_CYCLES.
- Stop sample, cycle S: T+H+9·BIT_CYCLES.
- FIFO write at the end of cycle S. `rx_valid` rises at S+1 if the FIFO was empty. `frame_err` is high during S+1 only.
- `busy` is high from T+1 until the cycle after the FSM returns to IDLE.
- The FSM re-arms in IDLE at S+1, so back-to-back frames with a one-bit stop are received without loss.
- Pop handshake: with `rx_valid` & `rx_ready` at cycle P, the next entry appears on `rx_data` at P+1. `rx_valid` falls at P+1 if that pop emptied the FIFO.
- Sustained throughput: one byte per 10·BIT_CYCLES.

## Test plan

All scenarios use BIT_CYCLES=16 and FIFO_DEPTH=4 unless stated.
- **Single byte:** send 0x55, `rx_ready`=1 → exactly one `rx_valid` cycle with `rx_data`=0x55 at S+1 (T+8+144+1). `frame_err`=0, `overflow`=0.
- **Glitch rejection:** drive `uart_rxd` low for 4 cycles, then high → no `rx_valid`, no `frame_err`. `busy` is high for 8 cycles, then returns to 0.
- **Framing error:** send 0xA3 with a low stop bit and hold low 3 more bit-times → one `frame_err` pulse, no push, `busy` stays high until the line rises. A following 0x3C is received correctly.
- **Overflow:** `rx_ready`=0, send 0x01..0x05 back-to-back → `overflow` rises at the 5th stop sample. Then raise `rx_ready` → reads 0x01, 0x02, 0x03, 0x04 in order, `overflow` stays 1.
- **Pop on full with a simultaneous push:** fill with 0x10..0x13, assert `rx_ready` for exactly the stop-sample cycle of 0x14 → `overflow`=0. Remaining reads are 0x11, 0x12, 0x13, 0x14.
- **Reset mid-frame:** assert `reset` during DATA bit 3 of 0xFF with one byte already queued → next cycle: `rx_valid`=0, `busy`=0, `overflow`=0. A subsequent 0x81 decodes correctly.

Source files
------------

// File: rtl/uart_rx_decoder.sv
// uart_rx_decoder: 8N1 UART receiver with a show-ahead output FIFO.
//
// Synchronises the asynchronous serial line, validates start bits at mid-bit, samples data
// LSB first, checks the stop bit and queues good bytes for a valid/ready consumer.
//
// Ports:
//   sys_clock  in   single clock, rising edge
//   reset      in   synchronous, active-high
//   uart_rxd   in   asynchronous serial line, idle high
//   rx_data    out  FIFO head byte, meaningful only while rx_valid
//   rx_valid   out  FIFO non-empty
//   rx_ready   in   consumer takes the head byte on rx_valid & rx_ready
//   frame_err  out  one-cycle pulse when a stop bit is sampled low
//   overflow   out  sticky, set when a good byte is dropped because the FIFO is full
//   busy       out  receiver FSM is not idle
module uart_rx_decoder #(
  parameter int unsigned BIT_CYCLES = 868,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned CtrW = $clog2(BIT_CYCLES);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [CtrW-1:0] HalfLast = CtrW'(BIT_CYCLES / 2 - 1);
  localparam logic [CtrW-1:0] BitLast  = CtrW'(BIT_CYCLES - 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  // Synchroniser; flops reset to the idle line level so reset never looks like a start bit.
  logic r_sync1;
  logic r_rxs;

  state_e          r_state, w_state_next;
  logic [CtrW-1:0] r_ctr, w_ctr_next;
  logic [2:0]      r_idx, w_idx_next;
  logic [7:0]      r_shift, w_shift_next;
  logic            r_frame_err, w_frame_err_next;
  logic            w_push;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            r_overflow;
  logic            w_full;
  logic            w_pop;
  logic            w_wr_en;
  logic            w_ovf_set;

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_rxs   <= r_sync1;
    end
  end

  // Receiver FSM: state register
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_state     <= StIdle;
      r_ctr       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ctr       <= w_ctr_next;
      r_idx       <= w_idx_next;
      r_shift     <= w_shift_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  // Receiver FSM: next state, bit timing and sampling
  always_comb begin
    w_state_next     = r_state;
    w_ctr_next       = r_ctr + 1'b1;
    w_idx_next       = r_idx;
    w_shift_next     = r_shift;
    w_frame_err_next = 1'b0;
    w_push           = 1'b0;

    case (r_state)
      StIdle: begin
        w_ctr_next = '0;
        if (!r_rxs) begin
          w_state_next = StStart;
        end
      end
      StStart: begin
        if (r_ctr == HalfLast) begin
          w_ctr_next = '0;
          if (r_rxs) begin
            // Line back high at mid start bit: a glitch, not a frame.
            w_state_next = StIdle;
          end else begin
            w_state_next = StData;
            w_idx_next   = '0;
          end
        end
      end
      StData: begin
        if (r_ctr == BitLast) begin
          w_ctr_next          = '0;
          w_shift_next[r_idx] = r_rxs;
          if (r_idx == 3'd7) begin
            w_state_next = StStop;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end
      StStop: begin
        if (r_ctr == BitLast) begin
          w_ctr_next = '0;
          if (r_rxs) begin
            // Return straight to idle so a following start edge is caught immediately.
            w_push       = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_frame_err_next = 1'b1;
            w_state_next     = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        w_ctr_next = '0;
        if (r_rxs) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_ctr_next   = '0;
        w_state_next = StIdle;
      end
    endcase
  end

  // Output FIFO
  assign w_full    = (r_count == CntFull);
  assign w_pop     = rx_valid & rx_ready;
  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign w_wr_en   = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  always_ff @(posedge sys_clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign rx_data   = r_mem[r_rd_ptr];
  assign rx_valid  = (r_count != '0);
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
  assign busy      = (r_state != StIdle);

endmodule
